// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter and initializer for a shared
// single-port memory with synchronous write and 1-cycle registered read.
// After reset the memory is swept with INIT_VALUE, then one access per cycle is
// granted. Read data returns two cycles after the grant on the matching port.
module mem_arbiter #(
   parameter int              AW         = 4,
   parameter int              DW         = 8,
   parameter logic [DW-1:0]   INIT_VALUE = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          r0_req,
   input  logic          r0_we,
   input  logic [AW-1:0] r0_a,
   input  logic [DW-1:0] r0_din,
   input  logic          r1_req,
   input  logic          r1_we,
   input  logic [AW-1:0] r1_a,
   input  logic [DW-1:0] r1_din,
   output logic          r0_gnt,
   output logic          r1_gnt,
   output logic          r0_rvalid,
   output logic          r1_rvalid,
   output logic [DW-1:0] r0_dout,
   output logic [DW-1:0] r1_dout,
   output logic          init_busy,
   output logic [AW-1:0] a,
   output logic [DW-1:0] din,
   output logic          we,
   input  logic [DW-1:0] dout
);

   typedef enum logic {ST_INIT, ST_ARB} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          last_winner_q, last_winner_d;
   logic [AW-1:0] a_q, a_d;
   logic [DW-1:0] din_q, din_d;
   logic          we_q, we_d;
   logic          rd_vld_p1_q, rd_vld_p1_d;
   logic          rd_id_p1_q, rd_id_p1_d;
   logic          rd_vld_p2_q, rd_id_p2_q;
   logic          gnt0, gnt1;

   // Grant selection: single requester wins outright; on conflict the one
   // that did not win last time is served. No grants while sweeping.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == ST_ARB) begin
         if (r0_req && r1_req) begin
            gnt0 = last_winner_q;
            gnt1 = ~last_winner_q;
         end else begin
            gnt0 = r0_req;
            gnt1 = r1_req;
         end
      end
   end

   // Next-state logic: init sweep address generation, memory port loading
   // from the winner, and stage-1 read tag (valid, requester id).
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      last_winner_d = last_winner_q;
      a_d           = a_q;
      din_d         = din_q;
      we_d          = 1'b0;
      rd_vld_p1_d   = 1'b0;
      rd_id_p1_d    = 1'b0;
      case (state_q)
         ST_INIT: begin
            a_d   = cnt_q;
            din_d = INIT_VALUE;
            we_d  = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {AW{1'b1}}) begin
               state_d = ST_ARB;
            end
         end
         ST_ARB: begin
            if (gnt0) begin
               a_d           = r0_a;
               din_d         = r0_din;
               we_d          = r0_we;
               last_winner_d = 1'b0;
               rd_vld_p1_d   = ~r0_we;
               rd_id_p1_d    = 1'b0;
            end else if (gnt1) begin
               a_d           = r1_a;
               din_d         = r1_din;
               we_d          = r1_we;
               last_winner_d = 1'b1;
               rd_vld_p1_d   = ~r1_we;
               rd_id_p1_d    = 1'b1;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State, memory port and read-return pipeline registers; reset restarts
   // the sweep and discards any read still in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_INIT;
         cnt_q         <= '0;
         last_winner_q <= 1'b1;
         a_q           <= '0;
         din_q         <= '0;
         we_q          <= 1'b0;
         rd_vld_p1_q   <= 1'b0;
         rd_id_p1_q    <= 1'b0;
         rd_vld_p2_q   <= 1'b0;
         rd_id_p2_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_winner_q <= last_winner_d;
         a_q           <= a_d;
         din_q         <= din_d;
         we_q          <= we_d;
         rd_vld_p1_q   <= rd_vld_p1_d;
         rd_id_p1_q    <= rd_id_p1_d;
         rd_vld_p2_q   <= rd_vld_p1_q;
         rd_id_p2_q    <= rd_id_p1_q;
      end
   end

   assign r0_gnt    = gnt0;
   assign r1_gnt    = gnt1;
   assign r0_rvalid = rd_vld_p2_q & ~rd_id_p2_q;
   assign r1_rvalid = rd_vld_p2_q & rd_id_p2_q;
   assign r0_dout   = dout;
   assign r1_dout   = dout;
   assign init_busy = (state_q == ST_INIT);
   assign a         = a_q;
   assign din       = din_q;
   assign we        = we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vectors against a behavioural 16x8
// memory with synchronous write and registered read.
module tb_mem_arbiter;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          r0_req, r0_we, r1_req, r1_we;
   logic [AW-1:0] r0_a, r1_a;
   logic [DW-1:0] r0_din, r1_din;
   logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, init_busy, we;
   logic [DW-1:0] r0_dout, r1_dout, din, mem_dout;
   logic [AW-1:0] a;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW), .INIT_VALUE(8'h00)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_a(r0_a), .r0_din(r0_din),
      .r1_req(r1_req), .r1_we(r1_we), .r1_a(r1_a), .r1_din(r1_din),
      .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
      .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
      .r0_dout(r0_dout), .r1_dout(r1_dout),
      .init_busy(init_busy), .a(a), .din(din), .we(we), .dout(mem_dout)
   );

   // Memory model; preloaded with FF so the init sweep must really clear it.
   logic [DW-1:0] mem [16] = '{default: 8'hFF};
   always @(posedge clk) begin
      if (we) mem[a] <= din;
      mem_dout <= mem[a];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic          r0_req, r0_we;
      logic [AW-1:0] r0_a;
      logic [DW-1:0] r0_din;
      logic          r1_req, r1_we;
      logic [AW-1:0] r1_a;
      logic [DW-1:0] r1_din;
      logic          g0, g1, v0, v1, we;
      logic [AW-1:0] a;
      logic [DW-1:0] din, dout;
   } vec_t;

   vec_t tbl [23];

   function automatic vec_t v(
      input logic q0, w0, input logic [3:0] a0, input logic [7:0] d0,
      input logic q1, w1, input logic [3:0] a1, input logic [7:0] d1,
      input logic g0, g1, v0, v1, ew, input logic [3:0] ea,
      input logic [7:0] ed, input logic [7:0] eq);
      vec_t r;
      r.r0_req = q0; r.r0_we = w0; r.r0_a = a0; r.r0_din = d0;
      r.r1_req = q1; r.r1_we = w1; r.r1_a = a1; r.r1_din = d1;
      r.g0 = g0; r.g1 = g1; r.v0 = v0; r.v1 = v1;
      r.we = ew; r.a = ea; r.din = ed; r.dout = eq;
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // write 3 then read-after-write
      tbl[0]  = v(1,1,3,8'hA5, 0,0,0,0,    1,0,0,0, 0,15,8'h00, 8'h00);
      tbl[1]  = v(0,0,0,0,     1,0,3,0,    0,1,0,0, 1,3, 8'hA5, 8'h00);
      tbl[2]  = v(0,0,0,0,     0,0,0,0,    0,0,0,0, 0,3, 8'h00, 8'h00);
      tbl[3]  = v(0,0,0,0,     0,0,0,0,    0,0,0,1, 0,3, 8'h00, 8'hA5);
      // preload addresses 1,2 (r0) and 4..7 (r1)
      tbl[4]  = v(1,1,1,8'h11, 0,0,0,0,    1,0,0,0, 0,3, 8'h00, 8'h00);
      tbl[5]  = v(1,1,2,8'h22, 0,0,0,0,    1,0,0,0, 1,1, 8'h11, 8'h00);
      tbl[6]  = v(0,0,0,0,     1,1,4,8'h44, 0,1,0,0, 1,2, 8'h22, 8'h00);
      tbl[7]  = v(0,0,0,0,     1,1,5,8'h55, 0,1,0,0, 1,4, 8'h44, 8'h00);
      tbl[8]  = v(0,0,0,0,     1,1,6,8'h66, 0,1,0,0, 1,5, 8'h55, 8'h00);
      tbl[9]  = v(0,0,0,0,     1,1,7,8'h77, 0,1,0,0, 1,6, 8'h66, 8'h00);
      // conflict: both held, r0 reads 1, r1 reads 2
      tbl[10] = v(1,0,1,0,     1,0,2,0,    1,0,0,0, 1,7, 8'h77, 8'h00);
      tbl[11] = v(1,0,1,0,     1,0,2,0,    0,1,0,0, 0,1, 8'h00, 8'h00);
      tbl[12] = v(1,0,1,0,     1,0,2,0,    1,0,1,0, 0,2, 8'h00, 8'h11);
      tbl[13] = v(1,0,1,0,     1,0,2,0,    0,1,0,1, 0,1, 8'h00, 8'h22);
      tbl[14] = v(0,0,0,0,     0,0,0,0,    0,0,1,0, 0,2, 8'h00, 8'h11);
      tbl[15] = v(0,0,0,0,     0,0,0,0,    0,0,0,1, 0,2, 8'h00, 8'h22);
      // r1 alone reads 4..7 back to back
      tbl[16] = v(0,0,0,0,     1,0,4,0,    0,1,0,0, 0,2, 8'h00, 8'h00);
      tbl[17] = v(0,0,0,0,     1,0,5,0,    0,1,0,0, 0,4, 8'h00, 8'h00);
      tbl[18] = v(0,0,0,0,     1,0,6,0,    0,1,0,1, 0,5, 8'h00, 8'h44);
      tbl[19] = v(0,0,0,0,     1,0,7,0,    0,1,0,1, 0,6, 8'h00, 8'h55);
      tbl[20] = v(0,0,0,0,     0,0,0,0,    0,0,0,1, 0,7, 8'h00, 8'h66);
      tbl[21] = v(0,0,0,0,     0,0,0,0,    0,0,0,1, 0,7, 8'h00, 8'h77);
      tbl[22] = v(0,0,0,0,     0,0,0,0,    0,0,0,0, 0,7, 8'h00, 8'h00);

      reset = 1'b1;
      r0_req = 0; r0_we = 0; r0_a = '0; r0_din = '0;
      r1_req = 0; r1_we = 0; r1_a = '0; r1_din = '0;
      @(posedge clk); #1;
      r1_req = 1'b1;
      #1;
      chk("rst_a", 32'(a), 32'd0);
      chk("rst_din", 32'(din), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_rv0", 32'(r0_rvalid), 32'd0);
      chk("rst_rv1", 32'(r1_rvalid), 32'd0);
      chk("rst_gnt0", 32'(r0_gnt), 32'd0);
      chk("rst_gnt1", 32'(r1_gnt), 32'd0);
      chk("rst_busy", 32'(init_busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("c0_we", 32'(we), 32'd0);

      // Init sweep with r1 requesting throughout, then r1 reads every word.
      for (int c = 1; c <= 33; c++) begin
         @(posedge clk); #1;
         r1_req = (c <= 31);
         r1_a   = (c >= 16) ? 4'(c - 16) : 4'd0;
         #1;
         if (c <= 16) begin
            chk("init_we", 32'(we), 32'd1);
            chk("init_a", 32'(a), 32'(c - 1));
            chk("init_din", 32'(din), 32'd0);
         end else if (c <= 32) begin
            chk("sweep_rd_we", 32'(we), 32'd0);
            chk("sweep_rd_a", 32'(a), 32'(c - 17));
         end
         chk("init_busy", 32'(init_busy), 32'(c < 16));
         chk("sweep_gnt0", 32'(r0_gnt), 32'd0);
         chk("sweep_gnt1", 32'(r1_gnt), 32'(c >= 16 && c <= 31));
         chk("sweep_rv0", 32'(r0_rvalid), 32'd0);
         chk("sweep_rv1", 32'(r1_rvalid), 32'(c >= 18 && c <= 33));
         if (c >= 18 && c <= 33) chk("sweep_dout", 32'(r1_dout), 32'd0);
      end

      // Table-driven ARB traffic.
      for (int i = 0; i < 23; i++) begin
         @(posedge clk); #1;
         r0_req = tbl[i].r0_req; r0_we = tbl[i].r0_we; r0_a = tbl[i].r0_a; r0_din = tbl[i].r0_din;
         r1_req = tbl[i].r1_req; r1_we = tbl[i].r1_we; r1_a = tbl[i].r1_a; r1_din = tbl[i].r1_din;
         #1;
         chk($sformatf("row%0d_gnt0", i), 32'(r0_gnt), 32'(tbl[i].g0));
         chk($sformatf("row%0d_gnt1", i), 32'(r1_gnt), 32'(tbl[i].g1));
         chk($sformatf("row%0d_rv0", i), 32'(r0_rvalid), 32'(tbl[i].v0));
         chk($sformatf("row%0d_rv1", i), 32'(r1_rvalid), 32'(tbl[i].v1));
         chk($sformatf("row%0d_we", i), 32'(we), 32'(tbl[i].we));
         chk($sformatf("row%0d_a", i), 32'(a), 32'(tbl[i].a));
         chk($sformatf("row%0d_din", i), 32'(din), 32'(tbl[i].din));
         if (tbl[i].v0) chk($sformatf("row%0d_dout0", i), 32'(r0_dout), 32'(tbl[i].dout));
         if (tbl[i].v1) chk($sformatf("row%0d_dout1", i), 32'(r1_dout), 32'(tbl[i].dout));
      end

      // Read granted, then reset the next cycle: the read must never return.
      @(posedge clk); #1;
      r0_req = 1'b1; r0_we = 1'b0; r0_a = 4'd3;
      #1;
      chk("mid_gnt0", 32'(r0_gnt), 32'd1);
      @(posedge clk); #1;
      r0_req = 1'b0;
      reset  = 1'b1;
      #1;
      chk("mid_rst_we", 32'(we), 32'd0);
      chk("mid_rst_a", 32'(a), 32'd0);
      chk("mid_rst_rv0", 32'(r0_rvalid), 32'd0);
      chk("mid_rst_busy", 32'(init_busy), 32'd1);
      @(posedge clk); #1;
      chk("mid_rst_rv0_late", 32'(r0_rvalid), 32'd0);
      chk("mid_rst_rv1_late", 32'(r1_rvalid), 32'd0);
      chk("mid_rst_we_late", 32'(we), 32'd0);
      reset = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         @(posedge clk); #1; #1;
         chk("re_init_we", 32'(we), 32'(c <= 16));
         if (c <= 16) chk("re_init_a", 32'(a), 32'(c - 1));
         chk("re_init_busy", 32'(init_busy), 32'(c < 16));
         chk("re_init_rv0", 32'(r0_rvalid), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and initializer for the shared 16x8 single-port memory (synchronous write, 1-cycle registered read). It sits between the memory and its clients, for example the key-driven editor and a display scanner. After reset it clears every word to INIT_VALUE, then grants one access per cycle using round-robin priority. Read data returns with a fixed 2-cycle latency after grant.

## Interface
- AW, 4, address width (memory depth 2**AW)
- DW, 8, data width
- INIT_VALUE, 0, value written to every word during the init sweep
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- r0_req, r1_req  in  1 each  access request; held high with stable we/a/din until grant
- r0_we, r1_we  in  1 each  1 = write, 0 = read
- r0_a, r1_a  in  AW each  address
- r0_din, r1_din  in  DW each  write data
- r0_gnt, r1_gnt  out  1 each  combinational grant pulse; the request is accepted in this cycle
- r0_rvalid, r1_rvalid  out  1 each  read data valid, one cycle per granted read
- r0_dout, r1_dout  out  DW each  read data (both equal memory dout; qualified by rvalid)
- init_busy  out  1  high while the init sweep is running
- a  out  AW  memory address (registered)
- din  out  DW  memory write data (registered)
- we  out  1  memory write enable (registered)
- dout  in  DW  memory read data, valid the cycle after a is presented

## Operation
- FSM states: INIT, ARB. Reset forces INIT with sweep counter = 0.
- INIT:
  - Each cycle, register a <= cnt, din <= INIT_VALUE, we <= 1; then cnt++.
  - After the cycle that issues cnt == 2**AW-1, the FSM moves to ARB.
  - No grants during INIT. Requests stay pending.
- ARB:
  - Each cycle, at most one gnt is asserted.
  - If only one req is high, that requester wins.
  - If both are high, the requester other than last_winner wins.
  - last_winner resets to 1, so r0 wins the first conflict. It updates on every grant.
  - The winner's we/a/din are registered onto the memory port.
  - If there is no grant, the next cycle has we = 0; a and din hold their values.
- Read return: a 2-stage pipeline carries (valid, id) for each granted read. At stage 2, the matching rX_rvalid pulses for one cycle.
- Writes produce no rvalid.
- A requester holding req continuously while the other is idle is granted every cycle.
- Counter arithmetic is AW bits. No wrap past 2**AW-1 occurs because the FSM exits first.

## Timing
- Reset values:
  - a = 0, din = 0, we = 0
  - r0_rvalid = r1_rvalid = 0, r0_gnt = r1_gnt = 0
  - init_busy = 1, last_winner = 1
- Init:
  - Memory-side we is high for exactly 2**AW consecutive cycles (16 by default), in cycles 1..16 after reset deasserts.
  - The address sequence is 0..15.
  - init_busy falls in the first ARB cycle. The earliest gnt is in that same cycle.
- Access latency, with grant in cycle N:
  - Memory sees a/we/din in cycle N+1.
  - A write takes effect at the end of N+1.
  - For a read, rvalid and valid dout occur in cycle N+2.
- Throughput is one access per cycle. Back-to-back reads give rvalid on consecutive cycles, in grant order.
- Read-after-write to the same address, granted in consecutive cycles N and N+1, returns the new data.
- Reset mid-operation:
  - Pipeline valids clear immediately.
  - Pending reads never return rvalid.
  - The init sweep restarts from address 0.

## Test plan
- Reset release with INIT_VALUE = 8'h00: we is high for 16 cycles with a = 0..15, no gnt, init_busy falls after; a read of each address then returns 8'h00.
- r0 writes 8'hA5 to address 3 with grant in cycle N; r1 reads address 3 granted in N+1 -> r1_rvalid in N+3 with dout = 8'hA5, and r0_rvalid stays 0.
- Both req held high in ARB, both reading addresses 1 and 2 -> first grant goes to r0, then grants alternate r1, r0, r1, ...; each rvalid arrives 2 cycles after its grant with the correct id.
- r1 req held high alone for 4 cycles (reads of 4..7) -> 4 consecutive gnts and 4 consecutive r1_rvalid pulses carrying the data for addresses 4..7.
- req asserted during INIT -> no gnt until the first ARB cycle, then granted immediately.
- reset asserted one cycle after a read grant -> no rvalid for that read, we = 0 during reset, the init sweep restarts at a = 0.
